// File: rtl/mc_ctrl.sv
// ---------------------------------------------------------------------------
// mc_ctrl - multi-cycle control unit for the MIPS32 datapath.
//
// The FSM walks each instruction only through the steps it needs:
//   j        : Fetch -> Decd
//   beq      : Fetch -> Decd -> Exe
//   R/ori/lui: Fetch -> Decd -> Exe -> WrBack
//   sw       : Fetch -> Decd -> Exe -> OpMem(wait)
//   lw       : Fetch -> Decd -> Exe -> OpMem(wait) -> WrBack
// Illegal opcodes and data-memory timeouts park the FSM in Trap until clr.
//
// Ports
//   clk, clr        : clock, asynchronous active-high reset
//   decdOp          : decoded opcode, stable from Decd until retire
//   zero            : ALU zero flag (used by beq in Exe)
//   dm_ack          : data-memory completion (only looked at in OpMem)
//   PCWr/IRWr/GPRWr : PC / IR / register-file write strobes
//   DMReq/DMWr      : data-memory request and write qualifier
//   ExtOp/RWSel/BSel/MemToReg/ALUOp : static decode of decdOp
//   nPCOp           : next-PC select (00 PC+4, 01 branch, 10 jump)
//   state           : current FSM state
//   trap/trap_cause : trap flag and cause (0 illegal, 1 memory timeout)
//   retired         : retired-instruction counter (wraps)
// ---------------------------------------------------------------------------
module mc_ctrl #(
  parameter int OP_W    = 7,
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 32,
  parameter int MEM_TMO = 15
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [OP_W-1:0]    decdOp,
  input  logic               zero,
  input  logic               dm_ack,
  output logic               PCWr,
  output logic               IRWr,
  output logic               GPRWr,
  output logic               DMReq,
  output logic               DMWr,
  output logic               ExtOp,
  output logic               RWSel,
  output logic               BSel,
  output logic               MemToReg,
  output logic [1:0]         nPCOp,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [2:0]         state,
  output logic               trap,
  output logic               trap_cause,
  output logic [CNT_W-1:0]   retired
);

  localparam int WAIT_W = (MEM_TMO < 1) ? 1 : $clog2(MEM_TMO + 1);

  localparam logic [OP_W-1:0] OP_ADDU = OP_W'(7'b1000011);
  localparam logic [OP_W-1:0] OP_SUBU = OP_W'(7'b1000111);
  localparam logic [OP_W-1:0] OP_SLT  = OP_W'(7'b1001010);
  localparam logic [OP_W-1:0] OP_ORI  = OP_W'(7'b0011010);
  localparam logic [OP_W-1:0] OP_LUI  = OP_W'(7'b0011110);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(7'b1000110);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(7'b1010110);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(7'b0001000);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(7'b0000100);

  localparam logic [2:0] ALU_NOP = 3'd0;
  localparam logic [2:0] ALU_ADD = 3'd1;
  localparam logic [2:0] ALU_SUB = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd4;
  localparam logic [2:0] ALU_SLT = 3'd5;
  localparam logic [2:0] ALU_LUI = 3'd7;

  typedef enum logic [2:0] {
    S_INIT   = 3'b000,
    S_FETCH  = 3'b001,
    S_DECD   = 3'b010,
    S_EXE    = 3'b011,
    S_OPMEM  = 3'b100,
    S_WRBACK = 3'b101,
    S_TRAP   = 3'b110,
    S_BAD    = 3'b111
  } state_e;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                cause_q, cause_d;
  logic [CNT_W-1:0]    ret_q;
  logic                ret_inc;

  logic is_addu, is_subu, is_slt, is_ori, is_lui, is_lw, is_sw, is_beq, is_j;
  logic is_legal;
  logic [2:0] alu_code;

  // Opcode match flags
  always_comb begin
    is_addu  = (decdOp == OP_ADDU);
    is_subu  = (decdOp == OP_SUBU);
    is_slt   = (decdOp == OP_SLT);
    is_ori   = (decdOp == OP_ORI);
    is_lui   = (decdOp == OP_LUI);
    is_lw    = (decdOp == OP_LW);
    is_sw    = (decdOp == OP_SW);
    is_beq   = (decdOp == OP_BEQ);
    is_j     = (decdOp == OP_J);
    is_legal = is_addu | is_subu | is_slt | is_ori | is_lui |
               is_lw | is_sw | is_beq | is_j;
  end

  // Static decode outputs, valid in every state
  always_comb begin
    ExtOp    = is_ori | is_lui | is_lw | is_sw | is_beq;
    BSel     = is_ori | is_lui | is_lw | is_sw;
    RWSel    = is_addu | is_subu | is_slt;
    MemToReg = ~is_lw;
    if (is_addu | is_lw | is_sw) begin
      alu_code = ALU_ADD;
    end else if (is_subu | is_beq) begin
      alu_code = ALU_SUB;
    end else if (is_slt) begin
      alu_code = ALU_SLT;
    end else if (is_ori) begin
      alu_code = ALU_OR;
    end else if (is_lui) begin
      alu_code = ALU_LUI;
    end else begin
      alu_code = ALU_NOP;
    end
    ALUOp = ALUOP_W'(alu_code);
  end

  // State register, memory wait counter, trap cause and retire counter
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_INIT;
      wait_q  <= WAIT_W'(0);
      cause_q <= 1'b0;
      ret_q   <= CNT_W'(0);
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
      if (ret_inc) begin
        ret_q <= ret_q + CNT_W'(1);
      end else begin
        ret_q <= ret_q;
      end
    end
  end

  // Next-state and Moore strobe logic; strobes follow state_q only, so an
  // asynchronous clr silences them immediately
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    cause_d = cause_q;
    ret_inc = 1'b0;
    PCWr    = 1'b0;
    IRWr    = 1'b0;
    GPRWr   = 1'b0;
    DMReq   = 1'b0;
    DMWr    = 1'b0;
    nPCOp   = 2'b00;
    trap    = 1'b0;
    case (state_q)
      S_INIT: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        IRWr    = 1'b1;
        PCWr    = 1'b1;
        state_d = S_DECD;
      end
      S_DECD: begin
        if (is_j) begin
          PCWr    = 1'b1;
          nPCOp   = 2'b10;
          ret_inc = 1'b1;
          state_d = S_FETCH;
        end else if (!is_legal) begin
          cause_d = 1'b0;
          state_d = S_TRAP;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        if (is_beq) begin
          nPCOp   = 2'b01;
          PCWr    = zero;
          ret_inc = 1'b1;
          state_d = S_FETCH;
        end else if (is_lw | is_sw) begin
          wait_d  = WAIT_W'(0);
          state_d = S_OPMEM;
        end else begin
          state_d = S_WRBACK;
        end
      end
      S_OPMEM: begin
        DMReq = 1'b1;
        DMWr  = is_sw;
        // An ack always wins, even in the cycle the counter hits the limit
        if (dm_ack) begin
          if (is_sw) begin
            ret_inc = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WRBACK;
          end
        end else if (wait_q == WAIT_W'(MEM_TMO)) begin
          cause_d = 1'b1;
          state_d = S_TRAP;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WRBACK: begin
        GPRWr   = 1'b1;
        ret_inc = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: begin
        trap = 1'b1;
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  assign state      = state_q;
  assign trap_cause = cause_q;
  assign retired    = ret_q;

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Parametrised multi-cycle control unit for the MIPS32 datapath.
- The FSM sequences per instruction class instead of a fixed six-step loop: jumps retire in Decd, branches in Exe, R/I-ALU ops skip OpMem.
- Adds gated write strobes, a data-memory request/acknowledge handshake with timeout, an illegal-opcode trap and a retired-instruction counter.
- Sits between the decoder (decdOp) and the PC/IR/GPR/DM/ALU datapath.

Parameters:
- OP_W, 7, width of decdOp.
- ALUOP_W, 4, width of ALUOp; must be >= 3.
- CNT_W, 32, width of retire counter.
- MEM_TMO, 15, max OpMem wait cycles before trap; >= 1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- clr  in  1  reset; asynchronous, active-high.
- decdOp  in  OP_W  decoded opcode from decoder; held stable from Decd until retire.
- zero  in  1  ALU zero flag; sampled in Exe.
- dm_ack  in  1  data memory completion.
- PCWr  out  1  PC write strobe.
- IRWr  out  1  IR write strobe.
- GPRWr  out  1  register file write strobe.
- DMReq  out  1  data memory request.
- DMWr  out  1  data memory write qualifier.
- ExtOp  out  1  1 = sign-extend immediate.
- RWSel  out  1  1 = rd destination, 0 = rt.
- BSel  out  1  1 = immediate to ALU B.
- MemToReg  out  1  0 = DM data to GPR, 1 = ALU result.
- nPCOp  out  2  00 PC+4, 01 branch, 10 jump.
- ALUOp  out  ALUOP_W  ALU op code.
- state  out  3  current FSM state.
- trap  out  1  FSM is in Trap.
- trap_cause  out  1  0 = illegal opcode, 1 = memory timeout.
- retired  out  CNT_W  retired-instruction count.

Behaviour:
- Opcode encodings (decdOp[6:0] when OP_W=7):
  - addu 1000011, subu 1000111, slt 1001010
  - ori 0011010, lui 0011110
  - lw 1000110, sw 1010110
  - beq 0001000, j 0000100
  - Any other value is illegal.
- ALU codes: nop 0, add 1, sub 2, or 4, slt 5, lui 7.
- States: Init 000, Fetch 001, Decd 010, Exe 011, OpMem 100, WrBack 101, Trap 110. Encoding 111 goes to Init.
- Reset (async, clr=1):
  - state=Init, retired=0, mem wait counter=0, trap_cause=0.
  - All strobes (PCWr, IRWr, GPRWr, DMReq, DMWr) are 0 immediately, without waiting for a clock edge.
- Static decode outputs are combinational from decdOp in every state:
  - ExtOp=1 for ori, lui, lw, sw, beq.
  - BSel=1 for ori, lui, lw, sw.
  - RWSel=1 for addu, subu, slt.
  - MemToReg=0 only for lw.
  - ALUOp: add for addu/lw/sw; sub for subu/beq; slt for slt; or for ori; lui for lui; nop otherwise. Zero-extended to ALUOP_W.
- Strobes are Moore outputs of state, qualified by decdOp and zero as listed:
  - Init: no strobes; next state Fetch.
  - Fetch: IRWr=1, PCWr=1, nPCOp=00; next Decd.
  - Decd:
    - j: PCWr=1, nPCOp=10, retired+1; next Fetch.
    - Illegal opcode: trap_cause<=0; next Trap.
    - Otherwise next Exe.
  - Exe:
    - beq: nPCOp=01, PCWr=zero, retired+1; next Fetch.
    - lw/sw: next OpMem, wait counter cleared.
    - All others: next WrBack.
  - OpMem:
    - DMReq=1; DMWr=1 iff sw.
    - dm_ack=1: lw goes to WrBack; sw retires (+1) and goes to Fetch.
    - dm_ack=0: counter increments. When the counter equals MEM_TMO with no ack, trap_cause<=1 and next Trap.
    - An ack in the same cycle the counter reaches MEM_TMO wins over the timeout.
  - WrBack: GPRWr=1, retired+1; next Fetch.
  - Trap: no strobes, trap=1; holds until clr.
- Latency in cycles from entering Fetch to retire:
  - j: 2
  - beq: 3
  - R-type / ori / lui: 4
  - sw: 4+wait
  - lw: 5+wait
- retired wraps modulo 2^CNT_W.
- dm_ack outside OpMem is ignored.
- clr asserted mid-instruction aborts it; no partial strobe is emitted afterwards.

Test Plan:
- clr pulse, then addu → states Init, Fetch, Decd, Exe, WrBack. GPRWr=1 only in WrBack. RWSel=1, ALUOp=1. retired=1 after WrBack.
- beq with zero=1, then beq with zero=0 → PCWr=1 with nPCOp=01 in Exe for the first, PCWr=0 for the second. Both retire; retired=2. No OpMem visited.
- lw with dm_ack delayed 3 cycles → DMReq=1 and DMWr=0 for 4 OpMem cycles, then WrBack with MemToReg=0 and GPRWr=1.
- sw with dm_ack never asserted, MEM_TMO=15 → exactly 16 OpMem cycles with DMWr=1, then Trap with trap=1, trap_cause=1. Stays in Trap until clr.
- decdOp=0000000 → Trap from Decd, trap_cause=0, no PCWr/GPRWr/DMWr. Asynchronous clr mid-Exe → state=Init within the same cycle.
- CNT_W=4: 17 j instructions → retired=1 (wrap). Each j takes 2 cycles with PCWr/nPCOp=10 in Decd.
